// File: rtl/serial_adder_ctrl_if.sv
// Handshake bundle for serial_adder_ctrl.
//   slave  : the adder (accepts operands, presents the result)
//   master : the producer/consumer side driving operands and out_ready
// Signals: in_valid/in_ready/a/b/c_in form the operand channel,
//          out_valid/out_ready/sum/c_out form the result channel,
//          busy is high while an operation is in flight or unclaimed.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, busy
  );

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, busy
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Multi-cycle wide adder: one SLICE-bit adder slice is reused across the
// WIDTH-bit operands, LSB slice first, carry registered between slices.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, aborts any operation
//   bus   : serial_adder_ctrl_if slave (operand and result handshakes, busy)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding slice idx, one slice per clock
// DONE  | result held with out_valid=1 until out_ready
module serial_adder_ctrl #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic              clk,
  input logic              reset,
  serial_adder_ctrl_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % SLICE) != 0) begin : g_bad_params
    $error("serial_adder_ctrl: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE:0]   slice_res;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  // Shared slice adder; operand slices are picked with a constant-index mux
  // so every part-select stays in range for any legal WIDTH/SLICE pair.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_sl = a_q[i*SLICE +: SLICE];
        b_sl = b_q[i*SLICE +: SLICE];
      end
    end
    slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.c_in;
          sum_d   = '0;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (idx_q == IDXW'(i)) begin
            sum_d[i*SLICE +: SLICE] = slice_res[SLICE-1:0];
          end
        end
        carry_d = slice_res[SLICE];
        if (idx_q == IDXW'(NSLICE - 1)) begin
          c_out_d = slice_res[SLICE];
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  logic clk;
  logic reset;
  int   cyc;
  int   n_total;
  int   n_pass;

  logic [WIDTH:0] exp_q[$];

  serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard monitor: every completed result handshake pops one expectation.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(exp_q.size()), 32'd1);
      end else begin
        check("result", {15'd0, bus.c_out, bus.sum}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  // Drive one request, wait (bounded) for acceptance, queue the reference
  // result. Returns #1 after the accepting edge with the accept cycle number.
  task automatic do_op(input logic [WIDTH-1:0] opa, input logic [WIDTH-1:0] opb,
                       input logic cin, output int acc_cyc);
    int n;
    logic [WIDTH:0] expv;
    bus.a        = opa;
    bus.b        = opb;
    bus.c_in     = cin;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("accept_timeout", 32'(bus.in_ready), 32'd1);
    expv = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc;
    int prev;
    int lat;
    logic [WIDTH-1:0] ra, rb;
    n_total = 0;
    n_pass  = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_c_out", 32'(bus.c_out), 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // Latency and hold behaviour with the consumer stalled.
    do_op(16'h1234, 16'h4321, 1'b0, acc);
    check("run_busy", 32'(bus.busy), 32'd1);
    check("run_in_ready", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.out_valid) break;
    end
    check("latency", 32'(lat), 32'(NSLICE));

    bus.a        = 16'hAAAA;
    bus.b        = 16'h5555;
    bus.c_in     = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_sum", 32'(bus.sum), 32'h5555);
      check("hold_c_out", 32'(bus.c_out), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    check("release_out_valid", 32'(bus.out_valid), 32'd0);
    check("release_busy", 32'(bus.busy), 32'd0);

    // Directed carry cases with the consumer always ready.
    bus.out_ready = 1'b1;
    do_op(16'h00F0, 16'h0010, 1'b0, acc);
    do_op(16'hFFFF, 16'h0001, 1'b0, acc);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, acc);
    do_op(16'h0000, 16'h0000, 1'b1, acc);
    drain();

    // Asynchronous reset while slice 2 is being added.
    do_op(16'h1111, 16'h2222, 1'b0, acc);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_sum", 32'(bus.sum), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    do_op(16'h8000, 16'h8000, 1'b0, acc);
    drain();

    // Random back-to-back traffic; accept spacing must be NSLICE+2 cycles.
    prev = 0;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0:       ra = 16'hFFFF;
        1:       ra = 16'h0000;
        default: ra = WIDTH'($urandom);
      endcase
      rb = WIDTH'($urandom);
      do_op(ra, rb, 1'($urandom_range(0, 1)), acc);
      if (i > 0) check("throughput", 32'(acc - prev), 32'(NSLICE + 2));
      prev = acc;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
